// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - instruction memory load/fetch sequencing controller
// Optional checksum trailer support: define IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  input  logic [31:0]       pc_addr_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_we_o,
  output logic              cpu_stall_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic              fetch_oor_o
);

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CKSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;
  logic [31:0]       asm_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W:0]   len_clamped;
  logic [31:0]       asm_next;
  logic              byte_fire;
  logic              start_fire;
  logic              words_done;

  // Lengths beyond the memory size are clamped so the write address never wraps.
  assign len_clamped = (load_len_i > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : load_len_i;
  assign asm_next    = {asm_q[23:0], byte_data_i};
  assign byte_fire   = byte_valid_i & byte_ready_o;
  assign start_fire  = (state == IDLE) & load_start_i;
  // The counter stops at len; once reached no further data bytes are taken.
  assign words_done  = (word_cnt == len_q);

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        err_q;

  // Running sum of written words and sticky trailer-compare result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (start_fire) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (we_q) begin
        sum_q <= sum_q + wdata_q;
      end
      if ((state == CKSUM) && byte_fire && (byte_cnt == 2'd3)) begin
        err_q <= (asm_next != sum_q);
      end
    end
  end

  assign load_err_o = err_q;
`else
  assign load_err_o = 1'b0;
`endif

  // State register, byte assembly, word counter and registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      waddr_q  <= '0;
    end else begin
      state <= state_nxt;
      we_q  <= 1'b0;
      if (start_fire) begin
        len_q    <= len_clamped;
        word_cnt <= '0;
        byte_cnt <= '0;
        waddr_q  <= '0;
      end
      if (byte_fire) begin
        asm_q    <= asm_next;
        byte_cnt <= byte_cnt + 2'd1;
        if ((state == LOAD) && (byte_cnt == 2'd3)) begin
          we_q     <= 1'b1;
          wdata_q  <= asm_next;
          waddr_q  <= word_cnt[ADDR_W-1:0];
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

  // Next-state decode and output muxing between fetch and load views.
  always_comb begin
    state_nxt    = state;
    byte_ready_o = 1'b0;
    cpu_stall_o  = 1'b1;
    load_busy_o  = 1'b1;
    load_done_o  = 1'b0;
    fetch_oor_o  = 1'b0;
    mem_addr_o   = waddr_q;
    mem_we_o     = we_q;
    mem_wdata_o  = wdata_q;
    case (state)
      IDLE: begin
        cpu_stall_o = 1'b0;
        load_busy_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        mem_addr_o  = pc_addr_i[ADDR_W+1:2];
        fetch_oor_o = (pc_addr_i[1:0] != 2'b00) | (pc_addr_i[31:ADDR_W+2] != '0);
        if (load_start_i) begin
          state_nxt = (len_clamped == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        byte_ready_o = ~words_done;
        if (words_done) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          state_nxt = CKSUM;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      CKSUM: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i && (byte_cnt == 2'd3)) begin
          state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        load_done_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic [31:0]       pc_addr = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              cpu_stall;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic              fetch_oor;

  imem_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .load_len_i(load_len),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
    .pc_addr_i(pc_addr), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .cpu_stall_o(cpu_stall), .load_busy_o(load_busy),
    .load_done_o(load_done), .load_err_o(load_err), .fetch_oor_o(fetch_oor)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int done_cnt = 0;
  int wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_w[DEPTH];
  logic [7:0] stim[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      last_we_cyc = cyc;
    end
    if (load_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: words go out most-significant byte first; trailer is the mod-2^32 word sum.
  task automatic build_stream(input int n, input logic [31:0] trailer_adj);
    logic [31:0] sum;
    sum = 0;
    stim.delete();
    for (int i = 0; i < n; i++) begin
      stim.push_back(8'((exp_w[i] / 32'h0100_0000) % 256));
      stim.push_back(8'((exp_w[i] / 32'h0001_0000) % 256));
      stim.push_back(8'((exp_w[i] / 32'h0000_0100) % 256));
      stim.push_back(8'(exp_w[i] % 256));
      sum = sum + exp_w[i];
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum = sum + trailer_adj;
    stim.push_back(sum[31:24]);
    stim.push_back(sum[23:16]);
    stim.push_back(sum[15:8]);
    stim.push_back(sum[7:0]);
`else
    if (trailer_adj != 0) sum = 0;
`endif
  endtask

  task automatic send_bytes(input int count, input bit gap);
    for (int i = 0; i < count; i++) begin
      int t;
      byte_valid = 1'b1;
      byte_data  = stim[i];
      t = 0;
      while (!byte_ready && t < 200) begin
        step();
        t++;
      end
      if (t >= 200) check("byte_ready_timeout", 32'(t), 32'd0);
      step();
      if (gap) begin
        byte_valid = 1'b0;
        byte_data  = 8'hxx;
        step();
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    t = 0;
    while (cpu_stall && t < 500) begin
      step();
      t++;
    end
    check("idle_timeout", 32'(t < 500), 32'd1);
  endtask

  task automatic start_load(input int len_req);
    load_start = 1'b1;
    load_len   = (ADDR_W+1)'(len_req);
    step();
    load_start = 1'b0;
  endtask

  task automatic run_load(input string tag, input int len_req, input bit gap, input logic [31:0] adj);
    int n;
    int t;
    n = (len_req > DEPTH) ? DEPTH : len_req;
    build_stream(n, adj);
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    start_load(len_req);
    check({tag, "_stall_start"}, 32'(cpu_stall), 32'd1);
    check({tag, "_busy_start"}, 32'(load_busy), 32'd1);
    send_bytes(stim.size(), gap);
    wait_idle(t);
`ifndef IMEM_LOAD_CHECKSUM_EN
    check({tag, "_stall_drop"}, 32'(cyc - last_we_cyc), 32'd2);
`endif
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_wr_cnt"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
      check({tag, "_data"}, wr_data[i], exp_w[i]);
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    check({tag, "_err"}, 32'(load_err), 32'(adj != 0));
`endif
  endtask

  initial begin
    int t;
    logic [31:0] pc;
    // Reset and fetch path.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    pc_addr = 32'h0000_000C;
    #1;
    check("fetch_addr_c", 32'(mem_addr), 32'd3);
    check("fetch_oor_c", 32'(fetch_oor), 32'd0);
    pc_addr = 32'h0000_0082;
    #1;
    check("fetch_oor_82", 32'(fetch_oor), 32'd1);
    pc_addr = 32'h0000_007C;
    #1;
    check("fetch_addr_7c", 32'(mem_addr), 32'd31);
    check("fetch_oor_7c", 32'(fetch_oor), 32'd0);
    pc_addr = 32'h0000_0080;
    #1;
    check("fetch_oor_80", 32'(fetch_oor), 32'd1);
    for (int i = 0; i < 8; i++) begin
      pc = (i % 2 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
      pc_addr = pc;
      #1;
      check("fetch_rand_addr", 32'(mem_addr), (pc / 4) % DEPTH);
      check("fetch_rand_oor", 32'(fetch_oor), 32'((pc % 4 != 0) || (pc >= 4 * DEPTH)));
    end
    pc_addr = '0;
    step();

    // Directed two-word load, back-to-back and gapped.
    exp_w[0] = 32'h2008_0005;
    exp_w[1] = 32'h2009_0007;
    run_load("two_word", 2, 1'b0, 32'd0);
    run_load("gapped", 2, 1'b1, 32'd0);

    // Zero length: DONE one cycle after start, then IDLE, no write.
    wr_addr.delete();
    start_load(0);
    check("zero_done", 32'(load_done), 32'd1);
    check("zero_stall", 32'(cpu_stall), 32'd1);
    step();
    check("zero_idle", 32'(cpu_stall), 32'd0);
    check("zero_no_write", 32'(wr_addr.size()), 32'd0);

    // Oversized length clamps to the memory depth.
    for (int i = 0; i < DEPTH; i++) exp_w[i] = $urandom;
    run_load("len40", 40, 1'b0, 32'd0);

    // Randomized loads.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) exp_w[i] = $urandom;
      run_load("rand", int'($urandom_range(1, 8)), bit'($urandom % 2), 32'd0);
    end

    // Reset after six bytes: only word 0 survives.
    exp_w[0] = 32'hA1B2_C3D4;
    exp_w[1] = 32'h5566_7788;
    build_stream(2, 32'd0);
    wr_addr.delete();
    wr_data.delete();
    start_load(2);
    send_bytes(6, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_wr_cnt", 32'(wr_addr.size()), 32'd1);
    if (wr_data.size() > 0) check("mid_rst_word0", wr_data[0], exp_w[0]);
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    check("mid_rst_busy", 32'(load_busy), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_done", 32'(load_done), 32'd0);
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_err", 32'(load_err), 32'd0);
    run_load("post_rst", 2, 1'b0, 32'd0);

`ifdef IMEM_LOAD_CHECKSUM_EN
    // Trailer 0x40110012 matches; 0x40110013 does not, cleared by next start.
    exp_w[0] = 32'h2008_0005;
    exp_w[1] = 32'h2009_000D;
    run_load("cksum_ok", 2, 1'b0, 32'd0);
    run_load("cksum_bad", 2, 1'b1, 32'd1);
    step();
    check("cksum_sticky", 32'(load_err), 32'd1);
    start_load(0);
    check("cksum_clear", 32'(load_err), 32'd0);
    wait_idle(t);
`endif

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
